// File: rtl/rx_vc_arbiter.sv
// rx_vc_arbiter: packet-granular round-robin arbiter feeding the RX adapter FIFO.
//
// Picks one requesting channel per packet and locks onto it until its eop beat
// transfers. While locked, the granted channel is passed straight through to
// the FIFO. New packets are granted only while the FIFO fill level is below
// FILL_THRESH.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   ch_valid/ch_data/ch_eop/ch_ready   per-channel beat interface (NUM_CH lanes)
//   out_valid/out_data/out_ready       beat interface toward the FIFO
//   fill_level            FIFO occupancy (0..16)
//   out_channel           index of the granted channel
//   busy                  high while a packet is locked
//   pkt_count             per-channel 32-bit eop counters (only with the macro below)
//
// Build option: define SONIC_VC_RX_ARB_STATS_EN to add the pkt_count port and
// its per-channel packet counters.

module rx_vc_arbiter #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DATA_WIDTH  = 133,
    parameter int unsigned FILL_THRESH = 12
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_eop,
    output logic [NUM_CH-1:0]            ch_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready,
    input  logic [4:0]                   fill_level,
    output logic [$clog2(NUM_CH)-1:0]    out_channel,
    output logic                         busy
`ifdef SONIC_VC_RX_ARB_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]         pkt_count
`endif
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e              state_q;
    logic [CH_W-1:0]     out_channel_q;
    logic [CH_W-1:0]     last_grant_q;

    logic [CH_W-1:0]     rr_pick;
    logic [CH_W-1:0]     rr_idx;
    logic                rr_found;
    logic                grant_ok;
    logic                beat_xfer;
    logic                pkt_done;

    logic [DATA_WIDTH-1:0] ch_beat [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_beat[i] = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search starting one past the last channel that finished a packet.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            rr_idx = CH_W'((32'(last_grant_q) + k) % NUM_CH);
            if (!rr_found && ch_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    assign grant_ok  = (state_q == StIdle) && rr_found && (32'(fill_level) < FILL_THRESH);
    assign beat_xfer = (state_q == StLocked) && ch_valid[out_channel_q] && out_ready;
    assign pkt_done  = beat_xfer && ch_eop[out_channel_q];

    // Reset value of last_grant makes channel 0 the first winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            out_channel_q <= '0;
            last_grant_q  <= CH_W'(NUM_CH - 1);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_ok) begin
                        out_channel_q <= rr_pick;
                        state_q       <= StLocked;
                    end
                end
                StLocked: begin
                    // No preemption: only the eop beat releases the lock.
                    if (pkt_done) begin
                        last_grant_q <= out_channel_q;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy        = (state_q == StLocked);
    assign out_channel = out_channel_q;
    assign out_valid   = busy && ch_valid[out_channel_q];
    assign out_data    = ch_beat[out_channel_q];

    always_comb begin
        ch_ready = '0;
        if (busy) begin
            ch_ready[out_channel_q] = out_ready;
        end
    end

`ifdef SONIC_VC_RX_ARB_STATS_EN
    logic [31:0] pkt_cnt_q [NUM_CH];

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pkt_cnt_q[i] <= '0;
            end
        end else if (pkt_done) begin
            pkt_cnt_q[out_channel_q] <= pkt_cnt_q[out_channel_q] + 32'd1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_stats
        assign pkt_count[i*32 +: 32] = pkt_cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_rx_vc_arbiter.sv
// Self-checking bench for rx_vc_arbiter: a packet-level reference model is
// compared against the DUT on every negative clock edge, with directed
// scenarios pinning grant order, threshold gating, stalls, back-to-back
// single-beat packets and mid-packet reset, followed by a randomized phase.

module tb_rx_vc_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 133;
    localparam int FT  = 12;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [NCH-1:0]    ch_valid = '0;
    logic [NCH*DW-1:0] ch_data = '0;
    logic [NCH-1:0]    ch_eop = '0;
    logic [NCH-1:0]    ch_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready = 1'b1;
    logic [4:0]        fill_level = '0;
    logic [1:0]        out_channel;
    logic              busy;
`ifdef SONIC_VC_RX_ARB_STATS_EN
    logic [NCH*32-1:0] pkt_count;
`endif

    rx_vc_arbiter #(
        .NUM_CH      (NCH),
        .DATA_WIDTH  (DW),
        .FILL_THRESH (FT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ch_valid    (ch_valid),
        .ch_data     (ch_data),
        .ch_eop      (ch_eop),
        .ch_ready    (ch_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .fill_level  (fill_level),
        .out_channel (out_channel),
`ifdef SONIC_VC_RX_ARB_STATS_EN
        .pkt_count   (pkt_count),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    bit m_locked = 1'b0;
    int m_grant  = 0;
    int m_last   = NCH - 1;

    // Winner = requesting channel at the smallest circular distance after 'last'.
    function automatic int rr_pick(input int last, input logic [NCH-1:0] v);
        int best   = -1;
        int best_d = NCH;
        for (int i = 0; i < NCH; i++) begin
            int d;
            d = (i - last - 1 + 2 * NCH) % NCH;
            if (v[i] && d < best_d) begin
                best   = i;
                best_d = d;
            end
        end
        return best;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_locked <= 1'b0;
            m_grant  <= 0;
            m_last   <= NCH - 1;
        end else if (!m_locked) begin
            if (ch_valid != '0 && int'(fill_level) < FT) begin
                m_locked <= 1'b1;
                m_grant  <= rr_pick(m_last, ch_valid);
            end
        end else if (ch_valid[m_grant] && out_ready && ch_eop[m_grant]) begin
            m_locked <= 1'b0;
            m_last   <= m_grant;
        end
    end

    logic           exp_busy;
    logic [1:0]     exp_ch;
    logic           exp_valid;
    logic [NCH-1:0] exp_ready;
    logic [DW-1:0]  exp_data;

    assign exp_busy  = m_locked;
    assign exp_ch    = 2'(m_grant);
    assign exp_valid = m_locked && ch_valid[m_grant];
    assign exp_ready = m_locked ? (NCH'(out_ready) << m_grant) : '0;
    assign exp_data  = ch_data[m_grant*DW +: DW];

    // ---------------- per-cycle compare ----------------
    logic [NCH-1:0] hs = '0;
    bit             prev_busy = 1'b0;
    int             cyc = 0;
    int             glog[$];
    int             gcyc[$];

    always @(negedge clk) begin
        chk("busy", 256'(busy), 256'(exp_busy));
        chk("out_channel", 256'(out_channel), 256'(exp_ch));
        chk("out_valid", 256'(out_valid), 256'(exp_valid));
        chk("ch_ready", 256'(ch_ready), 256'(exp_ready));
        if (exp_valid) chk("out_data", 256'(out_data), 256'(exp_data));
        if (busy && !prev_busy) begin
            glog.push_back(int'(out_channel));
            gcyc.push_back(cyc);
        end
        prev_busy <= busy;
        hs        <= ch_valid & ch_ready;
        cyc       <= cyc + 1;
    end

    // ---------------- stimulus ----------------
    bit             src_mode = 1'b1;
    logic [NCH-1:0] src_on = '0;
    int             bcnt[NCH];
    int             plen[NCH];
    int             npkt[NCH];
    int             pkt_lim[NCH];

    function automatic logic [DW-1:0] rand_beat();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // Packet sources: advance a beat on each handshake seen at the previous negedge.
    task automatic drive_src();
        for (int i = 0; i < NCH; i++) begin
            if (hs[i]) begin
                bcnt[i]++;
                if (bcnt[i] >= plen[i]) begin
                    bcnt[i] = 0;
                    npkt[i]++;
                    if (npkt[i] >= pkt_lim[i]) src_on[i] = 1'b0;
                end
                ch_data[i*DW +: DW] = rand_beat();
            end
            ch_valid[i] = src_on[i];
            ch_eop[i]   = (bcnt[i] == plen[i] - 1);
        end
    endtask

    task automatic drive_rand();
        ch_valid   = NCH'($urandom());
        for (int i = 0; i < NCH; i++) begin
            ch_eop[i] = ($urandom_range(0, 2) == 0);
            ch_data[i*DW +: DW] = rand_beat();
        end
        out_ready  = ($urandom_range(0, 3) != 0);
        fill_level = 5'($urandom_range(0, 16));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (src_mode) drive_src();
        else drive_rand();
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        src_mode   = 1'b1;
        src_on     = '0;
        ch_valid   = '0;
        ch_eop     = '0;
        out_ready  = 1'b1;
        fill_level = '0;
        for (int i = 0; i < NCH; i++) begin
            bcnt[i]    = 0;
            plen[i]    = 1;
            npkt[i]    = 0;
            pkt_lim[i] = 1000000;
            ch_data[i*DW +: DW] = rand_beat();
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    logic [DW-1:0] dstall;
    int            nx;

    initial begin
        // Reset state
        reset_n = 1'b0;
        #3;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_ch_ready", 256'(ch_ready), 256'(0));
        chk("rst_out_channel", 256'(out_channel), 256'(0));

        // All four channels, 2-beat packets: grants 0,1,2,3,0 every 3 cycles
        do_reset();
        glog.delete();
        gcyc.delete();
        for (int i = 0; i < NCH; i++) plen[i] = 2;
        src_on = '1;
        drive_src();
        repeat (16) cycle();
        chk("rr_grant_count_ge5", 256'(glog.size() >= 5), 256'(1));
        if (glog.size() >= 5) begin
            chk("rr_grant0", 256'(glog[0]), 256'(0));
            chk("rr_grant1", 256'(glog[1]), 256'(1));
            chk("rr_grant2", 256'(glog[2]), 256'(2));
            chk("rr_grant3", 256'(glog[3]), 256'(3));
            chk("rr_grant4", 256'(glog[4]), 256'(0));
            for (int i = 0; i < 4; i++) chk("rr_gap", 256'(gcyc[i+1] - gcyc[i]), 256'(3));
        end

        // Threshold gating: no grant at 12, grant one edge after dropping to 11
        do_reset();
        src_on[1]  = 1'b1;
        fill_level = 5'd12;
        drive_src();
        repeat (3) begin
            @(negedge clk);
            chk("thresh_busy_hold", 256'(busy), 256'(0));
            cycle();
        end
        fill_level = 5'd11;
        @(negedge clk);
        chk("thresh_busy_pre", 256'(busy), 256'(0));
        cycle();
        @(negedge clk);
        chk("thresh_busy", 256'(busy), 256'(1));
        chk("thresh_channel", 256'(out_channel), 256'(1));

        // Channel 2, 3-beat packet, two-cycle stall on beat 2
        do_reset();
        src_on[2] = 1'b1;
        plen[2]   = 3;
        drive_src();
        cycle();
        cycle();
        out_ready = 1'b0;
        dstall    = ch_data[2*DW +: DW];
        repeat (2) begin
            @(negedge clk);
            chk("stall_ready", 256'(ch_ready), 256'(0));
            chk("stall_valid", 256'(out_valid), 256'(1));
            chk("stall_data", 256'(out_data), 256'(dstall));
            cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_resume_ready", 256'(ch_ready), 256'(4'b0100));
        chk("stall_resume_data", 256'(out_data), 256'(dstall));
        cycle();
        @(negedge clk);
        chk("stall_eop_busy", 256'(busy), 256'(1));
        chk("stall_eop_flag", 256'(ch_eop[2]), 256'(1));
        src_on[2] = 1'b0;
        cycle();
        @(negedge clk);
        chk("stall_release", 256'(busy), 256'(0));

        // Ten single-beat packets on channel 0 over 20 cycles
        do_reset();
        src_on[0] = 1'b1;
        drive_src();
        nx = 0;
        repeat (20) begin
            @(negedge clk);
            if (ch_valid[0] && ch_ready[0]) nx++;
            chk("b2b_channel", 256'(out_channel), 256'(0));
            cycle();
        end
        chk("b2b_beats", 256'(nx), 256'(10));

        // Reset during beat 2 of a channel-3 packet
        do_reset();
        src_on[3] = 1'b1;
        plen[3]   = 3;
        drive_src();
        cycle();
        cycle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 256'(out_valid), 256'(0));
        chk("midrst_ch_ready", 256'(ch_ready), 256'(0));
        chk("midrst_busy", 256'(busy), 256'(0));
        @(negedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            bcnt[i] = 0;
            plen[i] = 1;
        end
        src_on = '1;
        glog.delete();
        gcyc.delete();
        drive_src();
        reset_n = 1'b1;
        repeat (3) cycle();
        chk("midrst_grant_count", 256'(glog.size() >= 1), 256'(1));
        if (glog.size() >= 1) chk("midrst_first_grant", 256'(glog[0]), 256'(0));

`ifdef SONIC_VC_RX_ARB_STATS_EN
        // Five packets on channel 1 only
        do_reset();
        src_on[1]  = 1'b1;
        plen[1]    = 2;
        pkt_lim[1] = 5;
        drive_src();
        for (int n = 0; n < 100 && npkt[1] < 5; n++) cycle();
        chk("stats_budget", 256'(npkt[1]), 256'(5));
        repeat (4) cycle();
        @(negedge clk);
        for (int i = 0; i < NCH; i++)
            chk("stats_count", 256'(pkt_count[i*32 +: 32]), 256'((i == 1) ? 5 : 0));
`endif

        // Randomized traffic against the model, with one asynchronous reset pulse
        do_reset();
        src_mode = 1'b0;
        drive_rand();
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (i == 1500) begin
                #2;
                reset_n = 1'b0;
                @(negedge clk);
                #1;
                reset_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_vc_arbiter.md
RX_VC_ARBITER -- requirements
Module: sonic_vc_rx_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4: number of requesting channels; legal values 2..8.
REQ-002 Parameter DATA_WIDTH, default 133: beat width, matching the RX adapter FIFO.
REQ-003 Parameter FILL_THRESH, default 12: a new packet SHALL be granted only while fill_level < FILL_THRESH.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ch_valid  in  NUM_CH  per-channel beat valid.
REQ-007 ch_data  in  NUM_CH*DATA_WIDTH  per-channel beat; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 ch_eop  in  NUM_CH  per-channel end-of-packet, qualified by ch_valid.
REQ-009 ch_ready  out  NUM_CH  per-channel ready.
REQ-010 out_valid  out  1  beat valid toward the FIFO in_valid.
REQ-011 out_data  out  DATA_WIDTH  beat toward the FIFO in_data.
REQ-012 out_ready  in  1  FIFO in_ready.
REQ-013 fill_level  in  5  FIFO occupancy, 0..16.
REQ-014 out_channel  out  clog2(NUM_CH)  index of the channel currently granted.
REQ-015 busy  out  1  high while a packet is locked.

Function
REQ-016 The FSM SHALL have two states: IDLE and LOCKED.
REQ-017 In IDLE, if any ch_valid is high and fill_level < FILL_THRESH, the block SHALL select one channel round-robin, searching upward from (last_grant+1) mod NUM_CH; it SHALL register that channel in out_channel and enter LOCKED at the next edge.
REQ-018 In IDLE, ch_ready SHALL be all zero and out_valid SHALL be 0.
REQ-019 In LOCKED, the output is a combinational pass-through: out_valid = ch_valid[g] and out_data = ch_data[g]; ch_ready[g] = out_ready; every other ch_ready bit SHALL be 0.
REQ-020 A beat transfers when ch_valid[g] and out_ready are both high; if ch_eop[g] is set on that beat, the FSM SHALL return to IDLE and last_grant SHALL become g.
REQ-021 A packet, once locked, SHALL NOT be preempted: fill_level is ignored in LOCKED, and an idle granted channel holds the lock indefinitely.
REQ-022 Minimum inter-packet gap: one IDLE cycle. Peak throughput is one beat per cycle within a packet.
REQ-023 Simultaneous requests SHALL be resolved strictly by round-robin order; no channel waits more than NUM_CH-1 packets.
REQ-024 A single-beat packet (eop on its first beat) SHALL occupy exactly one LOCKED cycle when out_ready is high.
REQ-025 If fill_level >= FILL_THRESH, IDLE SHALL persist with no grant and no change to last_grant.
REQ-026 busy SHALL equal (state == LOCKED).

Reset
REQ-027 Asserting reset_n low SHALL immediately force: state IDLE, out_channel 0, last_grant NUM_CH-1 (so channel 0 wins first), busy 0, out_valid 0, ch_ready 0.
REQ-028 Reset mid-packet SHALL abandon the packet; no recovery of partial packets is performed.

Configuration
REQ-029 Macro SONIC_VC_RX_ARB_STATS_EN: when defined, the block SHALL add output pkt_count of width NUM_CH*32, holding per-channel 32-bit counters that increment on each accepted eop beat, wrap from 0xFFFFFFFF to 0, and reset to 0; when undefined, the port and counters SHALL be absent and all other behaviour is identical.

Verification
REQ-030 Reset, then ch_valid=4'b1111 with 2-beat packets on every channel, out_ready=1, fill_level=0 -> grant order 0,1,2,3,0; each packet takes 2 LOCKED cycles plus 1 IDLE cycle.
REQ-031 Channel 2 sends a 3-beat packet; out_ready is low on beat 2 for 2 cycles -> ch_ready[2]=0 during the stall, out_data is held, no other ch_ready rises, and the lock is released only after the eop beat.
REQ-032 fill_level=12 with ch_valid[1]=1 -> no grant and busy=0; drop fill_level to 11 -> out_channel=1 and busy=1 one edge later.
REQ-033 Ten back-to-back single-beat packets on channel 0 only, out_ready=1 -> 10 beats transferred over 20 cycles, and out_channel stays 0.
REQ-034 reset_n pulsed low during beat 2 of a channel-3 packet -> out_valid=0, ch_ready=0 and busy=0 immediately; the next grant goes to channel 0.
REQ-035 With SONIC_VC_RX_ARB_STATS_EN defined: 5 packets on channel 1 -> pkt_count channel 1 = 5 and all other channel counters = 0.
